// File: rtl/noc_pkg.sv
// Shared flit layout helpers for the PE network interface.
// Flits are handled in a wide container and sliced by the user to its own widths.
package noc_pkg;
  localparam int cnt_w = 16;
  localparam int max_w = 256;

  typedef logic [max_w-1:0] flit_t;

  // Field offsets: dest x at bit 0, dest y above it, payload on top
  function automatic int x_lsb();
    return 0;
  endfunction

  function automatic int y_lsb(int x_size);
    return x_size;
  endfunction

  function automatic int data_lsb(int x_size, int y_size);
    return x_size + y_size;
  endfunction

  function automatic flit_t field_mask(int size);
    return (flit_t'(1) << size) - flit_t'(1);
  endfunction

  function automatic flit_t pack_flit(flit_t payload, flit_t x, flit_t y, int x_size, int y_size);
    return (payload << data_lsb(x_size, y_size))
         | ((y & field_mask(y_size)) << y_lsb(x_size))
         | ((x & field_mask(x_size)) << x_lsb());
  endfunction

  function automatic flit_t unpack_payload(flit_t flit, int x_size, int y_size);
    return flit >> data_lsb(x_size, y_size);
  endfunction

  function automatic flit_t unpack_x(flit_t flit, int x_size);
    return (flit >> x_lsb()) & field_mask(x_size);
  endfunction

  function automatic flit_t unpack_y(flit_t flit, int x_size, int y_size);
    return (flit >> y_lsb(x_size)) & field_mask(y_size);
  endfunction
endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous show-ahead FIFO; push is ignored when full, pop when empty.
// Full/empty come from registered level only, so a same-cycle pop never frees space.
module noc_sync_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [width-1:0]         din,
  output logic [width-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   level
);
  localparam int aw = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (level == (aw+1)'(depth));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only pointers and level do.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/noc_pe_interface.sv
// PE <-> switch network interface: TX/RX FIFOs, traffic counters, misroute flag.
// Switch-facing valid/data come from FIFO state only to break the switch's ready loop.
module noc_pe_interface
  import noc_pkg::*;
#(
  parameter int x_coord     = 0,
  parameter int y_coord     = 0,
  parameter int data_width  = 32,
  parameter int x_size      = 1,
  parameter int y_size      = 1,
  parameter int total_width = x_size + y_size + data_width,
  parameter int tx_depth    = 4,
  parameter int rx_depth    = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        i_pe_valid,
  output logic                        o_pe_ready,
  input  logic [data_width-1:0]       i_pe_data,
  input  logic [x_size-1:0]           i_pe_dest_x,
  input  logic [y_size-1:0]           i_pe_dest_y,
  output logic                        o_pe_valid,
  input  logic                        i_pe_ready,
  output logic [data_width-1:0]       o_pe_data,
  output logic                        o_noc_valid,
  input  logic                        i_noc_ready,
  output logic [total_width-1:0]      o_noc_data,
  input  logic                        i_noc_valid,
  output logic                        o_noc_ready,
  input  logic [total_width-1:0]      i_noc_data,
  output logic [$clog2(tx_depth):0]   o_tx_level,
  output logic [$clog2(rx_depth):0]   o_rx_level,
  output logic [cnt_w-1:0]            o_tx_flits,
  output logic [cnt_w-1:0]            o_rx_flits,
  output logic                        o_misroute
);
  logic                   tx_push, tx_pop, tx_full, tx_empty;
  logic                   rx_push, rx_pop, rx_full, rx_empty;
  logic [total_width-1:0] tx_flit, tx_head, rx_head;
  flit_t                  tx_wide, rx_payload, rx_x, rx_y, in_x, in_y;
  logic                   wrong_dest;

  assign tx_wide = pack_flit(flit_t'(i_pe_data), flit_t'(i_pe_dest_x), flit_t'(i_pe_dest_y),
                             x_size, y_size);
  assign tx_flit = tx_wide[total_width-1:0];

  assign o_pe_ready  = ~tx_full;
  assign o_noc_valid = ~tx_empty;
  assign o_noc_ready = ~rx_full;
  assign o_pe_valid  = ~rx_empty;

  assign tx_push = i_pe_valid  & o_pe_ready;
  assign tx_pop  = o_noc_valid & i_noc_ready;
  assign rx_push = i_noc_valid & o_noc_ready;
  assign rx_pop  = o_pe_valid  & i_pe_ready;

  noc_sync_fifo #(.width(total_width), .depth(tx_depth)) u_tx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (tx_flit),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (o_tx_level)
  );

  noc_sync_fifo #(.width(total_width), .depth(rx_depth)) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (i_noc_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .level (o_rx_level)
  );

  assign rx_payload = unpack_payload(flit_t'(rx_head), x_size, y_size);
  assign rx_x       = unpack_x(flit_t'(rx_head), x_size);
  assign rx_y       = unpack_y(flit_t'(rx_head), x_size, y_size);

  assign o_noc_data = tx_empty ? '0 : tx_head;
  assign o_pe_data  = rx_empty ? '0 : rx_payload[data_width-1:0];

  // Misroute is judged on the incoming flit at push time, not at delivery.
  assign in_x       = unpack_x(flit_t'(i_noc_data), x_size);
  assign in_y       = unpack_y(flit_t'(i_noc_data), x_size, y_size);
  assign wrong_dest = (in_x != flit_t'(x_coord)) | (in_y != flit_t'(y_coord));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_tx_flits <= '0;
      o_rx_flits <= '0;
      o_misroute <= 1'b0;
    end else begin
      if (tx_pop)  o_tx_flits <= o_tx_flits + 1'b1;
      if (rx_push) o_rx_flits <= o_rx_flits + 1'b1;
      if (rx_push & wrong_dest) o_misroute <= 1'b1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{tx_wide, rx_payload, rx_x, rx_y};
endmodule

// File: tb/tb_noc_pe_interface.sv
// Randomized + directed bench for noc_pe_interface against a queue-based model.
module tb_noc_pe_interface;
  localparam int DW = 32, XS = 1, YS = 1, TW = 34, TXD = 4, RXD = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic           i_pe_valid, o_pe_ready, o_pe_valid, i_pe_ready;
  logic [DW-1:0]  i_pe_data, o_pe_data;
  logic [XS-1:0]  i_pe_dest_x;
  logic [YS-1:0]  i_pe_dest_y;
  logic           o_noc_valid, i_noc_ready, i_noc_valid, o_noc_ready;
  logic [TW-1:0]  o_noc_data, i_noc_data;
  logic [2:0]     o_tx_level, o_rx_level;
  logic [15:0]    o_tx_flits, o_rx_flits;
  logic           o_misroute;

  noc_pe_interface dut (
    .clk(clk), .rstn(rstn),
    .i_pe_valid(i_pe_valid), .o_pe_ready(o_pe_ready), .i_pe_data(i_pe_data),
    .i_pe_dest_x(i_pe_dest_x), .i_pe_dest_y(i_pe_dest_y),
    .o_pe_valid(o_pe_valid), .i_pe_ready(i_pe_ready), .o_pe_data(o_pe_data),
    .o_noc_valid(o_noc_valid), .i_noc_ready(i_noc_ready), .o_noc_data(o_noc_data),
    .i_noc_valid(i_noc_valid), .o_noc_ready(o_noc_ready), .i_noc_data(i_noc_data),
    .o_tx_level(o_tx_level), .o_rx_level(o_rx_level),
    .o_tx_flits(o_tx_flits), .o_rx_flits(o_rx_flits), .o_misroute(o_misroute)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: FIFOs as queues, counters as plain integers
  logic [TW-1:0] m_tx[$];
  logic [TW-1:0] m_rx[$];
  logic [15:0]   m_txf = 0, m_rxf = 0;
  bit            m_mis = 0;
  bit            armed = 0;

  always @(posedge clk) begin
    bit tpush, tpop, rpush, rpop;
    if (!rstn) begin
      m_tx.delete(); m_rx.delete();
      m_txf = 0; m_rxf = 0; m_mis = 0; armed = 1;
    end else begin
      tpush = i_pe_valid && (m_tx.size() < TXD);
      tpop  = (m_tx.size() > 0) && i_noc_ready;
      rpush = i_noc_valid && (m_rx.size() < RXD);
      rpop  = (m_rx.size() > 0) && i_pe_ready;
      if (tpop) begin void'(m_tx.pop_front()); m_txf = m_txf + 1; end
      if (tpush) m_tx.push_back({i_pe_data, i_pe_dest_y, i_pe_dest_x});
      if (rpop) void'(m_rx.pop_front());
      if (rpush) begin
        m_rx.push_back(i_noc_data);
        m_rxf = m_rxf + 1;
        if (i_noc_data[XS+YS-1:0] != '0) m_mis = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("pe_ready",  64'(o_pe_ready),  64'(m_tx.size() < TXD));
      chk("noc_valid", 64'(o_noc_valid), 64'(m_tx.size() > 0));
      chk("noc_data",  64'(o_noc_data),  m_tx.size() > 0 ? 64'(m_tx[0]) : 64'd0);
      chk("tx_level",  64'(o_tx_level),  64'(m_tx.size()));
      chk("noc_ready", 64'(o_noc_ready), 64'(m_rx.size() < RXD));
      chk("pe_valid",  64'(o_pe_valid),  64'(m_rx.size() > 0));
      chk("pe_data",   64'(o_pe_data),   m_rx.size() > 0 ? 64'(m_rx[0][TW-1:XS+YS]) : 64'd0);
      chk("rx_level",  64'(o_rx_level),  64'(m_rx.size()));
      chk("tx_flits",  64'(o_tx_flits),  64'(m_txf));
      chk("rx_flits",  64'(o_rx_flits),  64'(m_rxf));
      chk("misroute",  64'(o_misroute),  64'(m_mis));
    end
  end

  task automatic idle_inputs();
    i_pe_valid = 0; i_pe_data = '0; i_pe_dest_x = '0; i_pe_dest_y = '0;
    i_pe_ready = 0; i_noc_valid = 0; i_noc_data = '0; i_noc_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
  endtask

  task automatic random_traffic(input int cycles, input bit any_dest);
    for (int i = 0; i < cycles; i++) begin
      i_pe_valid  = ($urandom_range(0, 3) != 0);
      i_pe_data   = $urandom;
      i_pe_dest_x = XS'($urandom);
      i_pe_dest_y = YS'($urandom);
      i_noc_ready = ($urandom_range(0, 2) != 0);
      i_noc_valid = ($urandom_range(0, 2) != 0);
      i_noc_data  = {32'($urandom), any_dest ? 2'($urandom) : 2'b00};
      i_pe_ready  = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    bit hit;
    idle_inputs();
    rstn = 0;
    repeat (2) @(negedge clk);
    chk("rst_noc_valid", 64'(o_noc_valid), 64'd0);
    chk("rst_pe_valid",  64'(o_pe_valid),  64'd0);
    chk("rst_pe_ready",  64'(o_pe_ready),  64'd1);
    chk("rst_noc_ready", 64'(o_noc_ready), 64'd1);
    chk("rst_levels",    64'({o_tx_level, o_rx_level}), 64'd0);
    chk("rst_counters",  64'({o_tx_flits, o_rx_flits}), 64'd0);
    chk("rst_data",      64'({o_noc_data, o_pe_data}), 64'd0);
    rstn = 1;

    // Single TX
    i_pe_valid = 1; i_pe_data = 32'hDEADBEEF; i_pe_dest_x = 1; i_pe_dest_y = 0; i_noc_ready = 1;
    @(negedge clk);
    i_pe_valid = 0;
    chk("tx1_valid", 64'(o_noc_valid), 64'd1);
    chk("tx1_flit",  64'(o_noc_data),  64'h37AB6FBBD);
    @(negedge clk);
    chk("tx1_after_valid", 64'(o_noc_valid), 64'd0);
    chk("tx1_count",       64'(o_tx_flits),  64'd1);

    // TX backpressure
    i_noc_ready = 0;
    for (int k = 0; k < 5; k++) begin
      i_pe_valid = 1; i_pe_data = 32'h1000 + k; i_pe_dest_x = XS'(k); i_pe_dest_y = YS'(k >> 1);
      @(negedge clk);
    end
    i_pe_valid = 0;
    chk("txbp_level", 64'(o_tx_level), 64'd4);
    chk("txbp_ready", 64'(o_pe_ready), 64'd0);
    i_noc_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("txbp_drain", 64'(o_noc_data[TW-1:XS+YS]), 64'(32'h1000 + k));
      @(negedge clk);
    end
    chk("txbp_empty", 64'(o_noc_valid), 64'd0);
    i_noc_ready = 0;

    // RX backpressure
    for (int k = 0; k < 5; k++) begin
      i_noc_valid = 1; i_noc_data = {32'h2000 + k, 2'b00};
      @(negedge clk);
    end
    i_noc_valid = 0;
    chk("rxbp_level", 64'(o_rx_level),  64'd4);
    chk("rxbp_ready", 64'(o_noc_ready), 64'd0);
    i_pe_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("rxbp_drain", 64'(o_pe_data), 64'(32'h2000 + k));
      @(negedge clk);
    end
    chk("rxbp_empty", 64'(o_pe_valid), 64'd0);
    chk("rxbp_no_misroute", 64'(o_misroute), 64'd0);

    // Misroute: x=1 at node (0,0)
    i_noc_valid = 1; i_noc_data = {32'hCAFE0001, 1'b0, 1'b1};
    @(negedge clk);
    i_noc_valid = 0;
    chk("mis_flag",    64'(o_misroute), 64'd1);
    chk("mis_payload", 64'(o_pe_data),  64'h0CAFE0001);
    random_traffic(300, 1'b0);
    chk("mis_sticky", 64'(o_misroute), 64'd1);
    do_reset();
    chk("mis_cleared", 64'(o_misroute), 64'd0);

    // Concurrent push/pop at level 2
    for (int k = 0; k < 2; k++) begin
      i_pe_valid = 1; i_pe_data = 32'h3000 + k;
      @(negedge clk);
    end
    chk("conc_pre", 64'(o_tx_level), 64'd2);
    i_noc_ready = 1;
    @(negedge clk);
    i_pe_valid = 0; i_noc_ready = 0;
    chk("conc_level", 64'(o_tx_level), 64'd2);

    // Random traffic with reset mid-operation
    random_traffic(1500, 1'b0);
    random_traffic(20, 1'b1);
    do_reset();
    random_traffic(1500, 1'b1);

    // Counter wrap
    do_reset();
    i_pe_valid = 1; i_noc_ready = 1;
    hit = 0;
    for (int i = 0; i < 70000 && !hit; i++) begin
      @(negedge clk);
      if (m_txf == 16'hFFFF) hit = 1;
    end
    chk("wrap_reached", 64'(hit), 64'd1);
    i_pe_valid = 0;
    @(negedge clk);
    chk("wrap_count", 64'(o_tx_flits), 64'd0);
    chk("wrap_level", 64'(o_tx_level), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
